// File: rtl/anti_droop_pkg.sv
// Shared types and widths for the anti-droop IIR sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package anti_droop_pkg;

    localparam int WEIGHT_W      = 7;
    localparam int BACKOFF_CNT_W = 4;
    // Width of the shared phase down-counter; phase lengths must fit below 2**CNT_W.
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARMED   = 3'd2,
        TRIG_HI = 3'd3,
        SETTLE  = 3'd4,
        BACKOFF = 3'd5
    } state_t;

endpackage

// File: rtl/anti_droop_weight_sat.sv
// Saturating step-toward-zero of a signed tap weight; never crosses zero.
// Latency: combinational.
// Backpressure: none.
// Ports: weight (current signed weight), weight_nxt (weight moved toward 0 by STEP).
// STEP is a magnitude and must be below 2**(WEIGHT_W+1).
module anti_droop_weight_sat
    import anti_droop_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [WEIGHT_W-1:0] weight_nxt
);

    // Two guard bits so w - STEP / w + STEP cannot wrap before the clamp.
    localparam logic signed [WEIGHT_W+1:0] STEP_X = (WEIGHT_W+2)'(STEP);

    logic signed [WEIGHT_W+1:0] w_x;
    logic signed [WEIGHT_W+1:0] w_dec;
    logic signed [WEIGHT_W+1:0] w_inc;

    always_comb begin
        w_x        = {{2{weight[WEIGHT_W-1]}}, weight};
        w_dec      = w_x - STEP_X;
        w_inc      = w_x + STEP_X;
        weight_nxt = weight;
        if (weight[WEIGHT_W-1]) begin
            // negative: clamp at zero if the step overshoots upward
            weight_nxt = (!w_inc[WEIGHT_W+1] && (w_inc != '0)) ? '0 : w_inc[WEIGHT_W-1:0];
        end else if (weight != '0) begin
            // positive: clamp at zero if the step overshoots downward
            weight_nxt = w_dec[WEIGHT_W+1] ? '0 : w_dec[WEIGHT_W-1:0];
        end
    end

endmodule

// File: rtl/anti_droop_ctrl.sv
// Sequencer for the anti-droop IIR: clears accumulator, shapes triggers, applies weights, supervises overflow.
// Latency: all outputs registered; trig_req in ARMED at t gives iir_trig at t+1..t+TRIG_W.
// Backpressure: none; trig_req outside ARMED (or with enable low) is dropped and flagged on trig_drop.
// Ports: enable/trig_req/weight_wr/weight_in/iir_oflow in; iir_trig, iir_accClr_en, iir_oflowClr,
//        iir_tapWeight, weight_ack, busy, trig_drop, backoff_cnt out.
// Build option: ANTIDROOP_AUTOBACKOFF_EN adds the BACKOFF state (overflow reduces weight and re-clears).
module anti_droop_ctrl
    import anti_droop_pkg::*;
#(
    parameter int CLR_CYC      = 4,
    parameter int TRIG_W       = 2,
    parameter int SETTLE_CYC   = 4,
    parameter int BACKOFF_STEP = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       trig_req,
    input  logic                       weight_wr,
    input  logic signed [WEIGHT_W-1:0] weight_in,
    output logic                       weight_ack,
    input  logic                       iir_oflow,
    output logic                       iir_trig,
    output logic                       iir_accClr_en,
    output logic                       iir_oflowClr,
    output logic signed [WEIGHT_W-1:0] iir_tapWeight,
    output logic                       busy,
    output logic                       trig_drop,
    output logic [BACKOFF_CNT_W-1:0]   backoff_cnt
);

    // Counter is loaded with length-1 on phase entry and the phase ends when it reads 0.
    localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] TRIG_LOAD   = CNT_W'(TRIG_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [WEIGHT_W-1:0] pend_q;
    logic                       pend_vld_q;
    logic                       apply;
    logic                       do_backoff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CLEAR;
                    cnt_d   = CLR_LOAD;
                end
                CLEAR: begin
                    if (cnt_q == '0) state_d = ARMED;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ARMED: begin
                    if (trig_req) begin
                        state_d = TRIG_HI;
                        cnt_d   = TRIG_LOAD;
                    end else if (pend_vld_q) begin
                        // a new weight always starts on a freshly cleared accumulator
                        apply   = 1'b1;
                        state_d = CLEAR;
                        cnt_d   = CLR_LOAD;
                    end
                end
                TRIG_HI: begin
                    if (cnt_q == '0) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
`ifdef ANTIDROOP_AUTOBACKOFF_EN
                        state_d = iir_oflow ? BACKOFF : ARMED;
`else
                        // overflow stays latched in the datapath for software
                        state_d = ARMED;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef ANTIDROOP_AUTOBACKOFF_EN
                BACKOFF: begin
                    state_d = CLEAR;
                    cnt_d   = CLR_LOAD;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef ANTIDROOP_AUTOBACKOFF_EN
    logic signed [WEIGHT_W-1:0] weight_bo;

    anti_droop_weight_sat #(
        .STEP (BACKOFF_STEP)
    ) u_weight_sat (
        .weight     (iir_tapWeight),
        .weight_nxt (weight_bo)
    );

    assign do_backoff = enable && (state_q == BACKOFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            backoff_cnt <= '0;
        end else if (do_backoff && (backoff_cnt != '1)) begin
            backoff_cnt <= backoff_cnt + 1'b1;
        end
    end
`else
    assign do_backoff  = 1'b0;
    assign backoff_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            iir_tapWeight <= '0;
            weight_ack    <= 1'b0;
            iir_trig      <= 1'b0;
            iir_accClr_en <= 1'b0;
            iir_oflowClr  <= 1'b0;
            busy          <= 1'b0;
            trig_drop     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            // outputs are decoded from the next state so they line up with the state register
            iir_accClr_en <= (state_d == CLEAR);
            iir_oflowClr  <= (state_d == CLEAR);
            iir_trig      <= (state_d == TRIG_HI);
            busy          <= !((state_d == IDLE) || (state_d == ARMED));
            trig_drop     <= trig_req && !(enable && (state_q == ARMED));
            weight_ack    <= apply;

            // a write in the same cycle as an apply/discard becomes the next pending weight
            if (weight_wr) begin
                pend_q     <= weight_in;
                pend_vld_q <= 1'b1;
            end else if (apply || do_backoff) begin
                pend_vld_q <= 1'b0;
            end

            if (apply) begin
                iir_tapWeight <= pend_q;
            end
`ifdef ANTIDROOP_AUTOBACKOFF_EN
            else if (do_backoff) begin
                iir_tapWeight <= weight_bo;
            end
`endif
        end
    end

endmodule

// File: tb/tb_anti_droop_ctrl.sv
// Directed self-checking bench for anti_droop_ctrl (default parameters).
// Latency: n/a.
// Backpressure: n/a.
module tb_anti_droop_ctrl;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              trig_req;
    logic              weight_wr;
    logic signed [6:0] weight_in;
    logic              iir_oflow;
    logic              weight_ack;
    logic              iir_trig;
    logic              iir_accClr_en;
    logic              iir_oflowClr;
    logic signed [6:0] iir_tapWeight;
    logic              busy;
    logic              trig_drop;
    logic [3:0]        backoff_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int overlap   = 0;
    int trig_rise = 0;
    int ack_cnt   = 0;
    int oclr_cnt  = 0;
    logic trig_prev = 1'b0;

    anti_droop_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .trig_req      (trig_req),
        .weight_wr     (weight_wr),
        .weight_in     (weight_in),
        .weight_ack    (weight_ack),
        .iir_oflow     (iir_oflow),
        .iir_trig      (iir_trig),
        .iir_accClr_en (iir_accClr_en),
        .iir_oflowClr  (iir_oflowClr),
        .iir_tapWeight (iir_tapWeight),
        .busy          (busy),
        .trig_drop     (trig_drop),
        .backoff_cnt   (backoff_cnt)
    );

`ifdef ANTIDROOP_AUTOBACKOFF_EN
    logic              weight_ack_5, iir_trig_5, iir_accClr_en_5, iir_oflowClr_5, busy_5, trig_drop_5;
    logic signed [6:0] iir_tapWeight_5;
    logic [3:0]        backoff_cnt_5;

    anti_droop_ctrl #(.BACKOFF_STEP(5)) dut5 (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .trig_req      (trig_req),
        .weight_wr     (weight_wr),
        .weight_in     (weight_in),
        .weight_ack    (weight_ack_5),
        .iir_oflow     (iir_oflow),
        .iir_trig      (iir_trig_5),
        .iir_accClr_en (iir_accClr_en_5),
        .iir_oflowClr  (iir_oflowClr_5),
        .iir_tapWeight (iir_tapWeight_5),
        .busy          (busy_5),
        .trig_drop     (trig_drop_5),
        .backoff_cnt   (backoff_cnt_5)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // running observations of properties that must hold on every cycle
    always @(negedge clk) begin
        if (iir_trig && iir_accClr_en) overlap++;
        if (iir_trig && !trig_prev)    trig_rise++;
        if (weight_ack)                ack_cnt++;
        if (iir_oflowClr)              oclr_cnt++;
        trig_prev = iir_trig;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_armed(input string tag, output int cyc);
        cyc = 0;
        while (busy && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, "_timeout"}, int'(busy), 0);
    endtask

    task automatic write_weight(input int v);
        int cyc;
        weight_in = 7'(v);
        weight_wr = 1'b1;
        tick();
        weight_wr = 1'b0;
        cyc = 0;
        while (!weight_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("wr_ack_seen", int'(weight_ack), 1);
        wait_armed("wr_clear", cyc);
    endtask

    task automatic fire(input string tag, output int cyc);
        trig_req = 1'b1;
        tick();
        trig_req = 1'b0;
        wait_armed(tag, cyc);
    endtask

    initial begin
        int n, cyc, trig0, oclr0, ack0, exp_w;

        rst_n     = 1'b0;
        enable    = 1'b0;
        trig_req  = 1'b0;
        weight_wr = 1'b0;
        weight_in = '0;
        iir_oflow = 1'b0;

        // reset state
        #12;
        chk("rst_trig",   int'(iir_trig), 0);
        chk("rst_clr",    int'(iir_accClr_en), 0);
        chk("rst_oclr",   int'(iir_oflowClr), 0);
        chk("rst_weight", int'(iir_tapWeight), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_bocnt",  int'(backoff_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // enable: four-cycle clear, then ARMED
        enable = 1'b1;
        tick();
        chk("en_busy", int'(busy), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(iir_accClr_en);
            tick();
        end
        chk("en_clr_len", n, 4);
        chk("en_armed_busy", int'(busy), 0);

        // trigger shape and a dropped request during SETTLE
        trig0 = trig_rise;
        trig_req = 1'b1;
        tick();
        trig_req = 1'b0;
        chk("trig_start", int'(iir_trig), 1);
        tick();
        chk("trig_2nd", int'(iir_trig), 1);
        tick();
        chk("trig_fall", int'(iir_trig), 0);
        trig_req = 1'b1;
        tick();
        trig_req = 1'b0;
        chk("settle_drop", int'(trig_drop), 1);
        tick();
        chk("drop_pulse", int'(trig_drop), 0);
        wait_armed("settle", cyc);
        chk("settle_pulses", trig_rise - trig0, 1);

        // weight 20 in ARMED: ack, weight and clear start together
        weight_in = 7'sd20;
        weight_wr = 1'b1;
        tick();
        weight_wr = 1'b0;
        tick();
        chk("w20_ack", int'(weight_ack), 1);
        chk("w20_val", int'(iir_tapWeight), 20);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(iir_accClr_en);
            tick();
        end
        chk("w20_clr_len", n, 4);

        // trigger and weight write together: trigger first, weight after SETTLE
        weight_in = -7'sd5;
        weight_wr = 1'b1;
        trig_req  = 1'b1;
        tick();
        weight_wr = 1'b0;
        trig_req  = 1'b0;
        chk("tw_trig", int'(iir_trig), 1);
        chk("tw_noack", int'(weight_ack), 0);
        chk("tw_old_w", int'(iir_tapWeight), 20);
        cyc = 0;
        while (!weight_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("tw_ack_delay", cyc, 7);
        chk("tw_new_w", int'(iir_tapWeight), -5);
        wait_armed("tw_clear", cyc);

`ifdef ANTIDROOP_AUTOBACKOFF_EN
        // overflow: backoff by 1 (dut) and 5 (dut5), with a pending weight discarded
        iir_oflow = 1'b1;
        oclr0 = oclr_cnt;
        ack0  = ack_cnt;
        trig_req = 1'b1;
        tick();
        trig_req  = 1'b0;
        weight_in = 7'sd9;
        weight_wr = 1'b1;
        tick();
        weight_wr = 1'b0;
        cyc = 0;
        while (busy && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("bo_cycles", cyc, 10);
        chk("bo_w_step1", int'(iir_tapWeight), -4);
        chk("bo_w_step5", int'(iir_tapWeight_5), 0);
        chk("bo_cnt1", int'(backoff_cnt), 1);
        chk("bo_oclr", oclr_cnt - oclr0, 4);
        repeat (3) tick();
        chk("bo_pend_discard", ack_cnt - ack0, 0);

        iir_oflow = 1'b0;
        write_weight(1);
        iir_oflow = 1'b1;
        fire("bo_w1", cyc);
        chk("bo_w1_zero", int'(iir_tapWeight), 0);
        chk("bo_cnt2", int'(backoff_cnt), 2);

        iir_oflow = 1'b0;
        write_weight(-3);
        iir_oflow = 1'b1;
        fire("bo_wm3", cyc);
        chk("bo_wm3_step1", int'(iir_tapWeight), -2);
        chk("bo_wm3_step5", int'(iir_tapWeight_5), 0);

        for (int i = 0; i < 14; i++) fire("bo_sat", cyc);
        chk("bo_cnt_sat", int'(backoff_cnt), 15);
        chk("bo_cnt_sat5", int'(backoff_cnt_5), 15);
        chk("bo_w_floor", int'(iir_tapWeight), 0);
        exp_w = 0;
`else
        // overflow with no backoff: back to ARMED, flag untouched, triggers keep running
        iir_oflow = 1'b1;
        oclr0 = oclr_cnt;
        fire("of", cyc);
        chk("of_cycles", cyc, 6);
        chk("of_no_oclr", oclr_cnt - oclr0, 0);
        chk("of_bocnt", int'(backoff_cnt), 0);
        chk("of_weight", int'(iir_tapWeight), -5);
        trig_req = 1'b1;
        tick();
        trig_req = 1'b0;
        chk("of_trig_again", int'(iir_trig), 1);
        wait_armed("of2", cyc);
        exp_w = -5;
`endif

        // enable drop mid-TRIG_HI
        iir_oflow = 1'b0;
        trig_req = 1'b1;
        tick();
        trig_req = 1'b0;
        chk("ed_trig_hi", int'(iir_trig), 1);
        enable = 1'b0;
        tick();
        chk("ed_trig_low", int'(iir_trig), 0);
        chk("ed_idle", int'(busy), 0);
        chk("ed_w_kept", int'(iir_tapWeight), exp_w);
        trig_req = 1'b1;
        tick();
        trig_req = 1'b0;
        chk("ed_drop", int'(trig_drop), 1);

        // asynchronous reset mid-CLEAR
        enable = 1'b1;
        tick();
        tick();
        chk("ar_clr_on", int'(iir_accClr_en), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_clr", int'(iir_accClr_en), 0);
        chk("ar_oclr", int'(iir_oflowClr), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_weight", int'(iir_tapWeight), 0);

        chk("no_trig_clr_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
